// File: rtl/mod_counter_ud_if.sv
// Control and status bundle for mod_counter_ud.
// The master drives the controls and the slave (the counter) drives count, tc and wrap.
interface mod_counter_ud_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_down;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output enable, clear, load, load_val, up_down, limit,
        input  count, tc, wrap
    );

    modport slave (
        input  enable, clear, load, load_val, up_down, limit,
        output count, tc, wrap
    );
endinterface

// File: rtl/mod_counter_ud.sv
// Up/down modulo counter with a runtime terminal value, parallel load, synchronous clear,
// wrap or saturate at the bounds, and terminal-count/wrap outputs for cascading.
module mod_counter_ud #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input logic              clk,
    input logic              rst,
    mod_counter_ud_if.slave  bus
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             at_top;
    logic             at_zero;

    // at_top uses >= so that a limit lowered below the count still ends the up range.
    assign at_top  = (count_q >= bus.limit);
    assign at_zero = (count_q == '0);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        count_d = count_q;
        wrap_d  = 1'b0;

        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                if (!at_top) begin
                    count_d = count_q + WIDTH'(1);
                end else if (SATURATE) begin
                    count_d = bus.limit;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q > bus.limit) begin
                    count_d = bus.limit;
                end else if (!at_zero) begin
                    count_d = count_q - WIDTH'(1);
                end else if (!SATURATE) begin
                    count_d = bus.limit;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.tc    = bus.enable & ((bus.up_down & at_top) | (~bus.up_down & at_zero));

endmodule

// File: tb/tb_mod_counter_ud.sv
// Self-checking bench for mod_counter_ud: a vector table in wrap and saturate modes,
// asynchronous reset, and a two-digit decimal cascade.
module tb_mod_counter_ud;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mod_counter_ud_if #(.WIDTH(W)) if_wrp ();
    mod_counter_ud_if #(.WIDTH(W)) if_sat ();
    mod_counter_ud_if #(.WIDTH(W)) if_lo  ();
    mod_counter_ud_if #(.WIDTH(W)) if_hi  ();

    mod_counter_ud #(.WIDTH(W), .SATURATE(1'b0)) u_wrp (.clk(clk), .rst(rst), .bus(if_wrp));
    mod_counter_ud #(.WIDTH(W), .SATURATE(1'b1)) u_sat (.clk(clk), .rst(rst), .bus(if_sat));
    mod_counter_ud #(.WIDTH(W), .SATURATE(1'b0)) u_lo  (.clk(clk), .rst(rst), .bus(if_lo));
    mod_counter_ud #(.WIDTH(W), .SATURATE(1'b0)) u_hi  (.clk(clk), .rst(rst), .bus(if_hi));

    // The tens digit steps whenever the units digit reaches its terminal count.
    assign if_hi.enable   = if_lo.tc;
    assign if_hi.clear    = 1'b0;
    assign if_hi.load     = 1'b0;
    assign if_hi.load_val = '0;
    assign if_hi.up_down  = 1'b1;
    assign if_hi.limit    = W'(9);

    typedef struct {
        string      name;
        bit         sel;
        bit         clr;
        bit         ld;
        logic [W-1:0] lv;
        bit         en;
        bit         ud;
        logic [W-1:0] lim;
        logic [W-1:0] e_count;
        bit         e_wrap;
        bit         e_tc;
    } vec_t;

    typedef struct {
        string      name;
        bit         sel;
        logic [W-1:0] count;
        bit         wrap;
        bit         tc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input bit sel, input bit clr, input bit ld,
                                input int lv, input bit en, input bit ud, input int lim,
                                input int ec, input bit ew, input bit et);
        vec_t v;
        v.name = name; v.sel = sel; v.clr = clr; v.ld = ld; v.lv = W'(lv);
        v.en = en; v.ud = ud; v.lim = W'(lim);
        v.e_count = W'(ec); v.e_wrap = ew; v.e_tc = et;
        return v;
    endfunction

    task automatic drive(input bit clr, input bit ld, input logic [W-1:0] lv,
                         input bit en, input bit ud, input logic [W-1:0] lim);
        if_wrp.clear = clr; if_wrp.load = ld; if_wrp.load_val = lv;
        if_wrp.enable = en; if_wrp.up_down = ud; if_wrp.limit = lim;
        if_sat.clear = clr; if_sat.load = ld; if_sat.load_val = lv;
        if_sat.enable = en; if_sat.up_down = ud; if_sat.limit = lim;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        drive(v.clr, v.ld, v.lv, v.en, v.ud, v.lim);
        e.name = v.name; e.sel = v.sel; e.count = v.e_count; e.wrap = v.e_wrap; e.tc = v.e_tc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({v.name, ".scoreboard_empty"}, 0, 1);
        end else begin
            got = exp_q.pop_front();
            if (got.sel) begin
                check({got.name, ".count"}, int'(if_sat.count), int'(got.count));
                check({got.name, ".wrap"},  int'(if_sat.wrap),  int'(got.wrap));
                check({got.name, ".tc"},    int'(if_sat.tc),    int'(got.tc));
            end else begin
                check({got.name, ".count"}, int'(if_wrp.count), int'(got.count));
                check({got.name, ".wrap"},  int'(if_wrp.wrap),  int'(got.wrap));
                check({got.name, ".tc"},    int'(if_wrp.tc),    int'(got.tc));
            end
        end
    endtask

    initial begin
        int lo_wraps;
        int hi_wraps;

        // name, sel, clr, ld, lv, en, ud, lim, exp_count, exp_wrap, exp_tc
        for (int i = 1; i <= 9; i++) vecs.push_back(mk("t1_up", 0, 0, 0, 0, 1, 1, 10, i, 0, 0));
        vecs.push_back(mk("t1_top",   0, 0, 0, 0, 1, 1, 10, 10, 0, 1));
        vecs.push_back(mk("t1_wrap",  0, 0, 0, 0, 1, 1, 10, 0, 1, 0));
        vecs.push_back(mk("t1_after", 0, 0, 0, 0, 1, 1, 10, 1, 0, 0));
        vecs.push_back(mk("t2_load",  0, 0, 1, 3, 1, 0, 10, 3, 0, 0));
        vecs.push_back(mk("t2_dn2",   0, 0, 0, 0, 1, 0, 10, 2, 0, 0));
        vecs.push_back(mk("t2_dn1",   0, 0, 0, 0, 1, 0, 10, 1, 0, 0));
        vecs.push_back(mk("t2_dn0",   0, 0, 0, 0, 1, 0, 10, 0, 0, 1));
        vecs.push_back(mk("t2_wrap",  0, 0, 0, 0, 1, 0, 10, 10, 1, 0));
        vecs.push_back(mk("t2_dn9",   0, 0, 0, 0, 1, 0, 10, 9, 0, 0));
        vecs.push_back(mk("t2s_load", 1, 0, 1, 3, 1, 0, 10, 3, 0, 0));
        vecs.push_back(mk("t2s_dn2",  1, 0, 0, 0, 1, 0, 10, 2, 0, 0));
        vecs.push_back(mk("t2s_dn1",  1, 0, 0, 0, 1, 0, 10, 1, 0, 0));
        vecs.push_back(mk("t2s_dn0",  1, 0, 0, 0, 1, 0, 10, 0, 0, 1));
        vecs.push_back(mk("t2s_hold", 1, 0, 0, 0, 1, 0, 10, 0, 0, 1));
        vecs.push_back(mk("t2s_hold", 1, 0, 0, 0, 1, 0, 10, 0, 0, 1));
        vecs.push_back(mk("sup_load", 1, 0, 1, 9, 1, 1, 10, 9, 0, 0));
        vecs.push_back(mk("sup_top",  1, 0, 0, 0, 1, 1, 10, 10, 0, 1));
        vecs.push_back(mk("sup_hold", 1, 0, 0, 0, 1, 1, 10, 10, 0, 1));
        vecs.push_back(mk("t3_load5", 0, 0, 1, 5, 0, 1, 10, 5, 0, 0));
        vecs.push_back(mk("t3_prio",  0, 1, 1, 7, 1, 1, 10, 0, 0, 0));
        vecs.push_back(mk("t3_clamp", 0, 0, 1, 14, 0, 1, 10, 10, 0, 0));
        vecs.push_back(mk("t3_clmpe", 0, 0, 1, 14, 1, 1, 10, 10, 0, 1));
        vecs.push_back(mk("t4_load8", 0, 0, 1, 8, 0, 1, 10, 8, 0, 0));
        vecs.push_back(mk("t4_uplow", 0, 0, 0, 0, 1, 1, 5, 0, 1, 0));
        vecs.push_back(mk("t4_relo8", 0, 0, 1, 8, 0, 1, 10, 8, 0, 0));
        vecs.push_back(mk("t4_dnlow", 0, 0, 0, 0, 1, 0, 5, 5, 0, 0));
        vecs.push_back(mk("t4s_ld8",  1, 0, 1, 8, 0, 1, 10, 8, 0, 0));
        vecs.push_back(mk("t4s_uplo", 1, 0, 0, 0, 1, 1, 5, 5, 0, 1));
        vecs.push_back(mk("l0_load",  0, 0, 1, 3, 0, 1, 10, 3, 0, 0));
        vecs.push_back(mk("l0_up",    0, 0, 0, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk("l0_up2",   0, 0, 0, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk("l0_dn",    0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk("l0s_load", 1, 0, 1, 5, 0, 1, 10, 5, 0, 0));
        vecs.push_back(mk("l0s_up",   1, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("l0s_dn",   1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("hold_ld",  0, 0, 1, 4, 0, 1, 10, 4, 0, 0));
        vecs.push_back(mk("hold_en0", 0, 0, 0, 0, 0, 1, 10, 4, 0, 0));
        vecs.push_back(mk("roll_ld",  0, 0, 1, 15, 0, 1, 15, 15, 0, 0));
        vecs.push_back(mk("roll_up",  0, 0, 0, 0, 1, 1, 15, 0, 1, 0));

        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, W'(10));
        if_lo.enable = 1'b0; if_lo.clear = 1'b0; if_lo.load = 1'b0;
        if_lo.load_val = '0; if_lo.up_down = 1'b1; if_lo.limit = W'(9);

        // Reset state while rst is held low across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst.count", int'(if_wrp.count), 0);
        check("rst.wrap",  int'(if_wrp.wrap),  0);
        check("rst.tc",    int'(if_wrp.tc),    0);
        check("rst.sat_count", int'(if_sat.count), 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset between edges, then release with enable held.
        @(negedge clk);
        drive(1'b0, 1'b1, W'(7), 1'b0, 1'b1, W'(10));
        @(posedge clk);
        #1;
        check("t5_load7", int'(if_wrp.count), 7);
        #3;
        rst = 1'b0;
        #1;
        check("t5_async.count", int'(if_wrp.count), 0);
        check("t5_async.wrap",  int'(if_wrp.wrap),  0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, W'(10));
        @(posedge clk);
        #1;
        check("t5_held", int'(if_wrp.count), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_first", int'(if_wrp.count), 1);

        // Two-digit decimal cascade from reset for 100 enabled edges.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6_rst_lo", int'(if_lo.count), 0);
        check("t6_rst_hi", int'(if_hi.count), 0);
        lo_wraps = 0;
        hi_wraps = 0;
        if_lo.enable = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (if_lo.wrap) lo_wraps++;
            if (if_hi.wrap) hi_wraps++;
            check($sformatf("t6_step%0d", i), int'(if_hi.count) * 10 + int'(if_lo.count), i % 100);
        end
        check("t6_hi_wrap_last", int'(if_hi.wrap), 1);
        check("t6_lo_wraps", lo_wraps, 10);
        check("t6_hi_wraps", hi_wraps, 1);
        @(negedge clk);
        if_lo.enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
